// File: rtl/data_memory.sv
// Word-organised, byte-addressed data RAM for the memory stage of the 16-bit core.
// Synchronous writes, combinational gated reads, asynchronous clear of the whole array.
module data_memory #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16,
   parameter int DEPTH      = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  MEMORY_WRITE_ENABLE,
   input  logic                  MEMORY_READ_ENABLE,
   input  logic [ADDR_WIDTH-1:0] MEMORY_ACCESS_ADDR,
   input  logic [DATA_WIDTH-1:0] MEMORY_WRITE_DATA,
   output logic [DATA_WIDTH-1:0] MEMORY_READ_DATA
);

   localparam int                    IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH-2:0] DEPTH_LIM = (ADDR_WIDTH-1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-2:0] word_idx;
   logic [IDX_W-1:0]      mem_idx;
   logic                  in_range;
   logic                  unused_addr_lsb;

   // Byte address bit 0 is dropped: odd addresses alias the even word below.
   assign word_idx        = MEMORY_ACCESS_ADDR[ADDR_WIDTH-1:1];
   assign unused_addr_lsb = MEMORY_ACCESS_ADDR[0];
   assign in_range        = (word_idx < DEPTH_LIM);
   assign mem_idx         = word_idx[IDX_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (MEMORY_WRITE_ENABLE && in_range) begin
         mem[mem_idx] <= MEMORY_WRITE_DATA;
      end
   end

   // An enable that is not a solid 1 (including X/Z) falls through to zero.
   always_comb begin
      MEMORY_READ_DATA = '0;
      if (MEMORY_READ_ENABLE && in_range) begin
         MEMORY_READ_DATA = mem[mem_idx];
      end
   end

endmodule

// File: tb/tb_data_memory.sv
// Randomised scoreboard bench for data_memory against an array-based reference model.
module tb_data_memory;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        we = 1'b0;
   logic        re = 1'b0;
   logic [15:0] addr = '0;
   logic [15:0] wdata = '0;
   logic [15:0] rdata;

   typedef struct {
      string       name;
      logic [15:0] exp;
   } sb_entry_t;

   sb_entry_t   sb [$];
   event        sample_ev;
   int          errors = 0;
   int          checks = 0;
   logic [15:0] model [32];

   data_memory dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .MEMORY_WRITE_ENABLE (we),
      .MEMORY_READ_ENABLE  (re),
      .MEMORY_ACCESS_ADDR  (addr),
      .MEMORY_WRITE_DATA   (wdata),
      .MEMORY_READ_DATA    (rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] model_read(input logic r, input logic [15:0] a);
      int idx;
      idx = int'(a) / 2;
      if (r && idx < 32) return model[idx];
      return 16'h0000;
   endfunction

   function automatic void model_write(input logic w, input logic [15:0] a, input logic [15:0] d);
      int idx;
      idx = int'(a) / 2;
      if (w && idx < 32) model[idx] = d;
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < 32; i++) model[i] = 16'h0000;
   endfunction

   task automatic expect_read(input string name, input logic [15:0] exp);
      sb_entry_t e;
      e.name = name;
      e.exp  = exp;
      sb.push_back(e);
      -> sample_ev;
      #2;
   endtask

   // Present a write on one rising edge; the model follows the edge.
   task automatic do_write(input logic [15:0] a, input logic [15:0] d);
      we = 1'b1; addr = a; wdata = d;
      @(posedge clk); #1;
      model_write(1'b1, a, d);
      we = 1'b0;
   endtask

   task automatic read_check(input string name, input logic [15:0] a);
      re = 1'b1; addr = a;
      expect_read(name, model_read(1'b1, a));
   endtask

   initial begin : monitor
      sb_entry_t e;
      forever begin
         @(sample_ev);
         #1;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: sample requested with no expected value, got %h", rdata);
         end else begin
            e = sb.pop_front();
            if (rdata !== e.exp) begin
               errors++;
               $display("FAIL %s: got %h expected %h (t=%0t)", e.name, rdata, e.exp, $time);
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      logic [15:0] a, d;
      logic        w, r;
      model_clear();

      // Reset state: contents read back as zero while reset is held.
      #1 rst_n = 1'b0;
      re = 1'b1; addr = 16'd0;
      expect_read("reset_addr0", 16'h0000);
      addr = 16'd62;
      expect_read("reset_addr62", 16'h0000);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Reset clears asynchronously, without a clock edge.
      do_write(16'd0, 16'hBEEF);
      read_check("beef_written", 16'd0);
      rst_n = 1'b0;
      model_clear();
      expect_read("async_clear", 16'h0000);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Sequential fill and readback.
      for (int k = 0; k < 32; k++) do_write(16'(2 * k), 16'(k + 1));
      for (int k = 0; k < 32; k++) begin
         re = 1'b1; addr = 16'(2 * k);
         expect_read($sformatf("fill_%0d", k), 16'(k + 1));
      end
      addr = 16'd62;
      expect_read("fill_top", 16'd32);

      // Odd-address aliasing in both directions.
      do_write(16'd6, 16'h1234);
      re = 1'b1; addr = 16'd7;
      expect_read("alias_read_odd", 16'h1234);
      do_write(16'd7, 16'h5678);
      re = 1'b1; addr = 16'd6;
      expect_read("alias_write_odd", 16'h5678);

      // Read-enable gating.
      do_write(16'd4, 16'h00AA);
      re = 1'b0; addr = 16'd4;
      expect_read("gate_off", 16'h0000);
      re = 1'b1;
      expect_read("gate_on", 16'h00AA);

      // Out-of-range writes are dropped.
      do_write(16'd64, 16'hFFFF);
      do_write(16'hFFFE, 16'hFFFF);
      re = 1'b1; addr = 16'd64;
      expect_read("oor_read_64", 16'h0000);
      addr = 16'hFFFE;
      expect_read("oor_read_fffe", 16'h0000);
      addr = 16'd0;
      expect_read("oor_word0", 16'd1);
      addr = 16'd62;
      expect_read("oor_word31", 16'd32);

      // Same-word read during write: old value before the edge, new after.
      do_write(16'd10, 16'd3);
      re = 1'b1; addr = 16'd10; wdata = 16'd9; we = 1'b1;
      expect_read("rdw_before", 16'd3);
      @(posedge clk); #1;
      model_write(1'b1, 16'd10, 16'd9);
      expect_read("rdw_after", 16'd9);
      we = 1'b0;

      // Write enable low: nothing changes over several edges.
      for (int i = 0; i < 8; i++) begin
         we = 1'b0; re = 1'b0;
         addr = 16'($urandom_range(0, 63)); wdata = 16'($urandom);
         @(posedge clk); #1;
      end
      for (int k = 0; k < 32; k++) read_check($sformatf("we_low_%0d", k), 16'(2 * k));

      // Randomised mixed traffic, mostly in range with occasional far addresses.
      for (int i = 0; i < 150; i++) begin
         w = 1'($urandom_range(0, 1));
         r = ($urandom_range(0, 3) != 0);
         a = ($urandom_range(0, 3) != 0) ? 16'($urandom_range(0, 63)) : 16'($urandom);
         d = 16'($urandom);
         we = w; re = r; addr = a; wdata = d;
         expect_read($sformatf("rand_pre_%0d", i), model_read(r, a));
         @(posedge clk); #1;
         model_write(w, a, d);
         expect_read($sformatf("rand_post_%0d", i), model_read(r, a));
      end
      we = 1'b0;
      for (int k = 0; k < 32; k++) read_check($sformatf("final_%0d", k), 16'(2 * k));

      #5;
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
